// File: rtl/spi_ram_burst_if.sv
// ---------------------------------------------------------------------------
// spi_ram_burst_if : framed command/data bundle between SPI front end and RAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spi_ram_burst_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH+1:0] din;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] dout;
  logic                  tx_valid;
  logic                  addr_err;
  logic                  seq_err;

  modport master (
    output din, rx_valid,
    input  dout, tx_valid, addr_err, seq_err
  );

  modport slave (
    input  din, rx_valid,
    output dout, tx_valid, addr_err, seq_err
  );
endinterface

`default_nettype wire

// File: rtl/spi_ram_burst.sv
// ---------------------------------------------------------------------------
// spi_ram_burst : parametrised single-port RAM with burst addressing behind SPI
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_ram_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_ram_burst_if.slave       spi_io
);

  localparam int                    IDX_W        = $clog2(MEM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] LAST_PAYLOAD = DATA_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0]  LAST_ADDR    = ADDR_SIZE'(MEM_DEPTH - 1);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  if ((ADDR_SIZE < 1) || (ADDR_SIZE > DATA_WIDTH) || (MEM_DEPTH < 2) ||
      (64'(MEM_DEPTH) > (64'(1) << ADDR_SIZE))) begin : g_bad_params
    $fatal(1, "spi_ram_burst: illegal ADDR_SIZE/DATA_WIDTH/MEM_DEPTH combination");
  end

  logic [1:0]            cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic [ADDR_SIZE-1:0]  addr;
  logic                  in_range;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
  logic                  wr_vld_q, wr_vld_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  addr_err_q, addr_err_d;
  logic                  seq_err_q, seq_err_d;

  assign cmd     = spi_io.din[DATA_WIDTH+1:DATA_WIDTH];
  assign payload = spi_io.din[DATA_WIDTH-1:0];
  assign addr    = payload[ADDR_SIZE-1:0];
  // Whole-payload compare: any nonzero bit above ADDR_SIZE is out of range too.
  assign in_range = (payload <= LAST_PAYLOAD);

  assign mem_we  = spi_io.rx_valid && (cmd == CMD_WR_DATA) && wr_vld_q;
  assign rd_data = mem_q[rd_addr_q[IDX_W-1:0]];

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
  endfunction

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_vld_d   = wr_vld_q;
    rd_vld_d   = rd_vld_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    addr_err_d = 1'b0;
    seq_err_d  = 1'b0;
    if (spi_io.rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: begin
          if (in_range) begin
            wr_addr_d = addr;
            wr_vld_d  = 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        CMD_WR_DATA: begin
          if (wr_vld_q) begin
            if (AUTO_INC) wr_addr_d = next_addr(wr_addr_q);
          end else begin
            seq_err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          if (in_range) begin
            rd_addr_d = addr;
            rd_vld_d  = 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        CMD_RD_DATA: begin
          if (rd_vld_q) begin
            dout_d     = rd_data;
            tx_valid_d = 1'b1;
            if (AUTO_INC) rd_addr_d = next_addr(rd_addr_q);
          end else begin
            seq_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_vld_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_vld_q   <= wr_vld_d;
      rd_vld_q   <= rd_vld_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      addr_err_q <= addr_err_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr_q[IDX_W-1:0]] <= payload;
  end

  assign spi_io.dout     = dout_q;
  assign spi_io.tx_valid = tx_valid_q;
  assign spi_io.addr_err = addr_err_q;
  assign spi_io.seq_err  = seq_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_burst.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_burst : three configurations driven in lockstep against a model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_ram_burst;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       drv_v = 1'b0;
  logic [9:0] drv_din = '0;

  always #5 clk = ~clk;

  spi_ram_burst_if #(.DATA_WIDTH(8)) bus_a ();
  spi_ram_burst_if #(.DATA_WIDTH(8)) bus_b ();
  spi_ram_burst_if #(.DATA_WIDTH(8)) bus_c ();

  assign bus_a.din = drv_din;  assign bus_a.rx_valid = drv_v;
  assign bus_b.din = drv_din;  assign bus_b.rx_valid = drv_v;
  assign bus_c.din = drv_din;  assign bus_c.rx_valid = drv_v;

  spi_ram_burst dut_a (.clk(clk), .rst(rst), .spi_io(bus_a));
  spi_ram_burst #(.MEM_DEPTH(200)) dut_b (.clk(clk), .rst(rst), .spi_io(bus_b));
  spi_ram_burst #(.AUTO_INC(1'b0)) dut_c (.clk(clk), .rst(rst), .spi_io(bus_c));

  logic [7:0] dut_dout [3];
  logic       dut_tx [3];
  logic       dut_ae [3];
  logic       dut_se [3];
  assign dut_dout[0] = bus_a.dout; assign dut_tx[0] = bus_a.tx_valid;
  assign dut_ae[0] = bus_a.addr_err; assign dut_se[0] = bus_a.seq_err;
  assign dut_dout[1] = bus_b.dout; assign dut_tx[1] = bus_b.tx_valid;
  assign dut_ae[1] = bus_b.addr_err; assign dut_se[1] = bus_b.seq_err;
  assign dut_dout[2] = bus_c.dout; assign dut_tx[2] = bus_c.tx_valid;
  assign dut_ae[2] = bus_c.addr_err; assign dut_se[2] = bus_c.seq_err;

  // Reference model: one entry per configuration.
  int         m_depth [3] = '{256, 200, 256};
  bit         m_ai    [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] m_mem   [3][256];
  bit         m_wr    [3][256];
  int         m_wa [3], m_ra [3];
  bit         m_wv [3], m_rv [3];
  logic [7:0] m_dout [3];
  bit         m_dk [3];
  bit         m_tx [3], m_ae [3], m_se [3];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit         v;
    logic [9:0] din;
    logic [7:0] e_dout;
    bit         e_tx;
    bit         e_se;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_wa[i] = 0; m_ra[i] = 0; m_wv[i] = 0; m_rv[i] = 0;
      m_dout[i] = 8'h00; m_dk[i] = 1'b1;
      m_tx[i] = 0; m_ae[i] = 0; m_se[i] = 0;
    end
  endfunction

  function automatic void model_step(input bit v, input logic [9:0] d);
    int pl;
    pl = int'(d[7:0]);
    for (int i = 0; i < 3; i++) begin
      m_tx[i] = 0; m_ae[i] = 0; m_se[i] = 0;
      if (v) begin
        case (d[9:8])
          2'b00: if (pl < m_depth[i]) begin m_wa[i] = pl; m_wv[i] = 1; end else m_ae[i] = 1;
          2'b01: if (m_wv[i]) begin
                   m_mem[i][m_wa[i]] = d[7:0];
                   m_wr[i][m_wa[i]] = 1'b1;
                   if (m_ai[i]) m_wa[i] = (m_wa[i] + 1) % m_depth[i];
                 end else m_se[i] = 1;
          2'b10: if (pl < m_depth[i]) begin m_ra[i] = pl; m_rv[i] = 1; end else m_ae[i] = 1;
          default: if (m_rv[i]) begin
                   m_dout[i] = m_mem[i][m_ra[i]];
                   m_dk[i] = m_wr[i][m_ra[i]];
                   m_tx[i] = 1;
                   if (m_ai[i]) m_ra[i] = (m_ra[i] + 1) % m_depth[i];
                 end else m_se[i] = 1;
        endcase
      end
    end
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model%0d.tx_valid", i), 32'(dut_tx[i]), 32'(m_tx[i]));
      chk($sformatf("model%0d.addr_err", i), 32'(dut_ae[i]), 32'(m_ae[i]));
      chk($sformatf("model%0d.seq_err", i), 32'(dut_se[i]), 32'(m_se[i]));
      if (m_dk[i]) chk($sformatf("model%0d.dout", i), 32'(dut_dout[i]), 32'(m_dout[i]));
    end
  endtask

  task automatic cycle(input bit v, input logic [9:0] d);
    drv_v   = v;
    drv_din = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, {2'b11, 8'h00}, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, {2'b01, 8'h55}, 8'h00, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, {2'b00, 8'd181}, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, {2'b01, 8'd230}, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, {2'b10, 8'd181}, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, {2'b11, 8'h00}, 8'd230, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, {2'b11, 8'h00}, 8'd230, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, {2'b00, 8'd254}, 8'd230, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, {2'b01, 8'd1}, 8'd230, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, {2'b01, 8'd2}, 8'd230, 1'b0, 1'b0};
    tbl[10] = '{1'b1, {2'b01, 8'd3}, 8'd230, 1'b0, 1'b0};
    tbl[11] = '{1'b1, {2'b10, 8'd254}, 8'd230, 1'b0, 1'b0};
    tbl[12] = '{1'b1, {2'b11, 8'h00}, 8'd1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, {2'b11, 8'h00}, 8'd2, 1'b1, 1'b0};
    tbl[14] = '{1'b1, {2'b11, 8'h00}, 8'd3, 1'b1, 1'b0};
    tbl[15] = '{1'b0, {2'b00, 8'h00}, 8'd3, 1'b0, 1'b0};

    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d.dout", i), 32'(dut_dout[i]), 32'h0);
      chk($sformatf("reset%0d.flags", i), {29'd0, dut_tx[i], dut_ae[i], dut_se[i]}, 32'h0);
    end

    // Directed vectors against the default configuration.
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].v, tbl[i].din);
      chk($sformatf("vec%0d.dout", i), 32'(dut_dout[0]), 32'(tbl[i].e_dout));
      chk($sformatf("vec%0d.tx_valid", i), 32'(dut_tx[0]), 32'(tbl[i].e_tx));
      chk($sformatf("vec%0d.seq_err", i), 32'(dut_se[0]), 32'(tbl[i].e_se));
    end

    // Depth 200: out-of-range address leaves the pointer alone, then wraps.
    cycle(1'b1, {2'b00, 8'd199});
    cycle(1'b1, {2'b00, 8'd200});
    chk("depth200.addr_err", 32'(dut_ae[1]), 32'h1);
    chk("depth256.addr_err", 32'(dut_ae[0]), 32'h0);
    cycle(1'b1, {2'b01, 8'd9});
    cycle(1'b1, {2'b01, 8'd10});
    cycle(1'b1, {2'b10, 8'd199});
    cycle(1'b1, {2'b11, 8'h00});
    chk("depth200.rd199", 32'(dut_dout[1]), 32'd9);
    cycle(1'b1, {2'b11, 8'h00});
    chk("depth200.rd0_wrap", 32'(dut_dout[1]), 32'd10);
    chk("depth200.tx_valid", 32'(dut_tx[1]), 32'h1);

    // Idle cycles with a read command on the bus must not advance anything.
    cycle(1'b1, {2'b00, 8'd5});
    cycle(1'b1, {2'b01, 8'h5A});
    cycle(1'b1, {2'b10, 8'd5});
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, {2'b11, 8'h00});
      chk($sformatf("idle%0d.tx_valid", k), 32'(dut_tx[0]), 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, {2'b11, 8'h00});
      chk($sformatf("noinc%0d.dout", k), 32'(dut_dout[2]), 32'h5A);
      chk($sformatf("noinc%0d.tx_valid", k), 32'(dut_tx[2]), 32'h1);
      if (k == 0) chk("idle.rd_addr_held", 32'(dut_dout[0]), 32'h5A);
    end

    // Asynchronous reset in the middle of a burst.
    cycle(1'b1, {2'b00, 8'd11});
    cycle(1'b1, {2'b01, 8'h33});
    cycle(1'b1, {2'b00, 8'd10});
    cycle(1'b1, {2'b01, 8'h07});
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_rst%0d.dout", i), 32'(dut_dout[i]), 32'h0);
      chk($sformatf("async_rst%0d.flags", i), {29'd0, dut_tx[i], dut_ae[i], dut_se[i]}, 32'h0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, {2'b01, 8'h08});
    for (int i = 0; i < 3; i++) chk($sformatf("post_rst%0d.seq_err", i), 32'(dut_se[i]), 32'h1);
    cycle(1'b1, {2'b10, 8'd11});
    cycle(1'b1, {2'b11, 8'h00});
    for (int i = 0; i < 3; i++) chk($sformatf("post_rst%0d.mem11", i), 32'(dut_dout[i]), 32'h33);

    // Fill every location, then random traffic against the model.
    cycle(1'b1, {2'b00, 8'd0});
    for (int k = 0; k < 256; k++) cycle(1'b1, {2'b01, 8'($urandom_range(0, 255))});
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        do_reset();
        @(posedge clk); #1;
        compare_all();
      end
      cycle(($urandom_range(0, 3) != 0), {2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
- Parametrised single-port synchronous RAM behind the SPI slave front end; successor to the fixed 256x8 command RAM.
- Accepts framed words {cmd[1:0], payload} from the SPI receive path.
- Adds generic widths, non-power-of-2 depth, optional address auto-increment for burst transfers, address range checking, and command sequencing checks.
- Read data returns to the SPI transmit path with a one-cycle tx_valid pulse.

Parameters:
DATA_WIDTH, 8, memory word width and payload width.
ADDR_SIZE, 8, address register width; must satisfy ADDR_SIZE <= DATA_WIDTH.
MEM_DEPTH, 256, number of words; must satisfy 1 < MEM_DEPTH <= 2**ADDR_SIZE.
AUTO_INC, 1, 1 = address post-increments after each data access; 0 = address holds.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
din  input  DATA_WIDTH+2  cmd = din[DATA_WIDTH+1:DATA_WIDTH]; payload = din[DATA_WIDTH-1:0].
rx_valid  input  1  din valid this cycle; no command executes without it.
dout  output  DATA_WIDTH  registered read data.
tx_valid  output  1  one-cycle pulse: dout updated this cycle.
addr_err  output  1  one-cycle pulse: address command payload >= MEM_DEPTH.
seq_err  output  1  one-cycle pulse: data command issued with no valid address loaded.

Behaviour:
- Reset (async assert, sync-safe release): wr_addr = 0, rd_addr = 0, wr_vld = 0, rd_vld = 0, dout = 0, tx_valid = 0, addr_err = 0, seq_err = 0. Memory contents are not reset.
- Address used = payload[ADDR_SIZE-1:0]. Upper payload bits are ignored for range checking only when they are zero. Any nonzero upper bit counts as out of range.
- All commands below act only on a clk edge with rx_valid = 1. With rx_valid = 0, no state changes except that tx_valid, addr_err and seq_err drop to 0.
- cmd 00 (write address):
  - If in range: wr_addr <= addr, wr_vld <= 1.
  - Else: addr_err pulses; wr_addr and wr_vld are unchanged.
- cmd 01 (write data):
  - If wr_vld: mem[wr_addr] <= payload; if AUTO_INC, wr_addr <= next(wr_addr).
  - Else: seq_err pulses; no write occurs.
- cmd 10 (read address): same as cmd 00, but acts on rd_addr and rd_vld.
- cmd 11 (read data):
  - If rd_vld: dout <= mem[rd_addr] and tx_valid <= 1 on that edge, i.e. 1-cycle latency from command to data. If AUTO_INC, rd_addr <= next(rd_addr).
  - Else: seq_err pulses, dout holds, tx_valid = 0.
- next(a) = 0 if a == MEM_DEPTH-1, else a+1. Wrap-around is silent, with no error flag.
- tx_valid, addr_err and seq_err are each high for exactly one cycle per triggering command. Back-to-back commands give back-to-back pulses.
- dout holds its last value between reads.
- Write and read pointers are independent. A read-data command issued the cycle after a write-data command to the same address returns the new data.
- Only one command exists per cycle, so there is no simultaneous read and write.
- Reset mid-burst: pointers and valid flags clear immediately. The next data command without a fresh address command yields seq_err.
- Parameter violations must stop elaboration (generate-time check).

Test Plan:
- Defaults; reset, then {11, x} with rx_valid = 1 -> seq_err pulse, tx_valid = 0, dout = 0. Then {01, 0x55} -> seq_err pulse, no write.
- {00, 181}, {01, 230}, {10, 181}, {11, x} -> on the cycle after the last command: dout = 230, tx_valid = 1 for one cycle, then tx_valid = 0 and dout holds 230.
- Burst write, AUTO_INC = 1: {00, 254}, then {01, 1}, {01, 2}, {01, 3} -> mem[254] = 1, mem[255] = 2, mem[0] = 3 (wrap). {10, 254}, then three {11} -> dout = 1, 2, 3 with tx_valid high on three consecutive cycles.
- MEM_DEPTH = 200: {00, 200} -> addr_err pulse, wr_addr unchanged. {00, 199}, {01, 9}, {01, 10} -> mem[199] = 9, mem[0] = 10.
- rx_valid = 0 with din = {11, x} held for 5 cycles -> tx_valid stays 0 and rd_addr does not advance. AUTO_INC = 0: three {11} at addr 5 -> dout = mem[5] three times.
- Assert rst after {00, 10}, {01, 7} mid-burst -> all outputs 0 asynchronously. After release, {01, 8} -> seq_err pulse and mem[11] is unchanged.
